// File: rtl/prediction_voter.sv
// prediction_voter: temporal majority filter between the digit classifier and the display.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pred_valid     one-cycle pulse qualifying pred_in
//   pred_in[3:0]   raw class, 0..9 digit, 10..15 "no digit"
//   stable_digit   filtered digit, 4'hF when blank
//   stable_valid   stable_digit holds a digit
//   confidence     history count of the stable digit, 0 when blank
//   digit_changed  one-cycle pulse when stable_digit changes value
//   busy           FSM is processing a prediction
module prediction_voter #(
    parameter int DEPTH          = 8,
    parameter int THRESHOLD      = 5,
    parameter int RELEASE        = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pred_valid,
    input  logic [3:0] pred_in,
    output logic [3:0] stable_digit,
    output logic       stable_valid,
    output logic [3:0] confidence,
    output logic       digit_changed,
    output logic       busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] TH4  = 4'(THRESHOLD);
    localparam logic [3:0] REL4 = 4'(RELEASE);
    localparam logic [1:0] S_IDLE = 2'd0, S_UPDATE = 2'd1, S_SCAN = 2'd2, S_DECIDE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    hist_q [DEPTH];
    logic [3:0]    hist_d [DEPTH];
    logic [3:0]    cnt_q [10];
    logic [3:0]    cnt_d [10];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pend_q, pend_d;
    logic [3:0]    pend_val_q, pend_val_d;
    logic [3:0]    cur_q, cur_d;
    logic [3:0]    idx_q, idx_d, max_cnt_q, max_cnt_d, max_idx_q, max_idx_d;
    logic [3:0]    digit_q, digit_d, conf_q, conf_d;
    logic          valid_q, valid_d, chg_q, chg_d;

    logic [3:0] old_val, cnt_idx, cnt_s, cnt_max, new_digit, new_conf;
    logic       full, new_valid, timeout;

    // Decision logic for DECIDE plus the counter lookups it and SCAN need.
    always_comb begin
        old_val = hist_q[ptr_q];
        full    = fill_q == FILL_MAX;
        cnt_idx = '0;
        cnt_s   = '0;
        cnt_max = '0;
        for (int k = 0; k < 10; k++) begin
            if (idx_q == 4'(k))     cnt_idx = cnt_q[k];
            if (digit_q == 4'(k))   cnt_s   = cnt_q[k];
            if (max_idx_q == 4'(k)) cnt_max = cnt_q[k];
        end
        new_digit = digit_q;
        new_valid = valid_q;
        if (!valid_q && max_cnt_q >= TH4) begin
            new_digit = max_idx_q;
            new_valid = 1'b1;
        end else if (valid_q && max_idx_q != digit_q && max_cnt_q >= TH4 && max_cnt_q > cnt_s) begin
            new_digit = max_idx_q;
        end else if (valid_q && cnt_s < REL4) begin
            new_digit = 4'hF;
            new_valid = 1'b0;
        end
        new_conf = !new_valid ? 4'd0 : (new_digit == max_idx_q) ? cnt_max : cnt_s;
        // A prediction on the expiry cycle cancels the timeout.
        timeout  = state_q == S_IDLE && !pred_valid && tmo_q == TMO_LAST;
    end

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cur_d      = cur_q;
        idx_d      = idx_q;
        max_cnt_d  = max_cnt_q;
        max_idx_d  = max_idx_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        conf_d     = conf_q;
        chg_d      = 1'b0;
        tmo_d      = pred_valid ? '0 : (state_q == S_IDLE) ? tmo_q + 1'b1 : tmo_q;
        // Single-entry pending slot: the newest pulse seen while busy wins.
        if (pred_valid && state_q != S_IDLE) begin
            pend_d     = 1'b1;
            pend_val_d = pred_in;
        end
        case (state_q)
            S_IDLE: begin
                if (pred_valid) begin
                    cur_d   = pred_in;
                    state_d = S_UPDATE;
                end else if (timeout) begin
                    for (int i = 0; i < DEPTH; i++) hist_d[i] = 4'hF;
                    for (int k = 0; k < 10; k++) cnt_d[k] = '0;
                    ptr_d   = '0;
                    fill_d  = '0;
                    tmo_d   = '0;
                    digit_d = 4'hF;
                    valid_d = 1'b0;
                    conf_d  = '0;
                    chg_d   = valid_q;
                end
            end
            S_UPDATE: begin
                // Remove the evicted entry and add the new one; values >9 touch no counter.
                for (int k = 0; k < 10; k++)
                    cnt_d[k] = cnt_q[k] - {3'b0, full && old_val == 4'(k)} + {3'b0, cur_q == 4'(k)};
                hist_d[ptr_q] = cur_q;
                ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                fill_d    = full ? fill_q : fill_q + 1'b1;
                idx_d     = '0;
                max_cnt_d = '0;
                max_idx_d = '0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                // Strictly greater keeps the lowest index on ties.
                if (cnt_idx > max_cnt_q) begin
                    max_cnt_d = cnt_idx;
                    max_idx_d = idx_q;
                end
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == 4'd9) ? S_DECIDE : S_SCAN;
            end
            default: begin
                digit_d = new_digit;
                valid_d = new_valid;
                conf_d  = new_conf;
                chg_d   = new_digit != digit_q;
                pend_d  = 1'b0;
                state_d = (pred_valid || pend_q) ? S_UPDATE : S_IDLE;
                cur_d   = pred_valid ? pred_in : pend_val_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= 4'hF;
            for (int k = 0; k < 10; k++) cnt_q[k] <= '0;
            ptr_q      <= '0;
            fill_q     <= '0;
            tmo_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            cur_q      <= '0;
            idx_q      <= '0;
            max_cnt_q  <= '0;
            max_idx_q  <= '0;
            digit_q    <= 4'hF;
            valid_q    <= 1'b0;
            conf_q     <= '0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            fill_q     <= fill_d;
            tmo_q      <= tmo_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            cur_q      <= cur_d;
            idx_q      <= idx_d;
            max_cnt_q  <= max_cnt_d;
            max_idx_q  <= max_idx_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            conf_q     <= conf_d;
            chg_q      <= chg_d;
        end
    end

    assign stable_digit  = digit_q;
    assign stable_valid  = valid_q;
    assign confidence    = conf_q;
    assign digit_changed = chg_q;
    assign busy          = state_q != S_IDLE;
endmodule

// File: tb/tb_prediction_voter.sv
// tb_prediction_voter: directed bench for prediction_voter with a 100-cycle timeout.
// Ports: none (drives clk, rst_n, pred_valid, pred_in; observes all DUT outputs).
module tb_prediction_voter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pred_valid = 1'b0;
    logic [3:0] pred_in = 4'd0;
    logic [3:0] stable_digit;
    logic       stable_valid;
    logic [3:0] confidence;
    logic       digit_changed;
    logic       busy;
    int total = 0;
    int bad = 0;
    int chg = 0;

    prediction_voter #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_in(pred_in),
        .stable_digit(stable_digit), .stable_valid(stable_valid), .confidence(confidence),
        .digit_changed(digit_changed), .busy(busy)
    );

    always #5 clk = ~clk;

    // {stable_valid, stable_digit, confidence}
    function automatic logic [8:0] outs();
        return {stable_valid, stable_digit, confidence};
    endfunction

    task automatic wait_n(input int n);
        repeat (n) begin
            @(negedge clk);
            if (digit_changed === 1'b1) chg++;
        end
    endtask

    // Called at a negedge; the pulse is sampled on the following posedge.
    task automatic pulse(input logic [3:0] v);
        pred_valid = 1'b1;
        pred_in    = v;
        @(negedge clk);
        pred_valid = 1'b0;
    endtask

    // Returns right after the DECIDE edge, outputs already updated.
    task automatic feed(input logic [3:0] v);
        pulse(v);
        wait_n(12);
    endtask

    task automatic do_reset();
        pred_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chg = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({outs(), digit_changed, busy} !== {1'b0, 4'hF, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", {outs(), digit_changed, busy}, {1'b0, 4'hF, 4'd0, 2'b00});
        end
    endtask

    task automatic test_majority();
        do_reset();
        for (int i = 0; i < 4; i++) feed(4'd7);
        total++;
        if (outs() !== {1'b0, 4'hF, 4'd0}) begin
            bad++;
            $display("FAIL majority_before5: got %h want %h", outs(), {1'b0, 4'hF, 4'd0});
        end
        pulse(4'd7);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL majority_busy: got %b want 1", busy);
        end
        wait_n(11);
        total++;
        if (stable_valid !== 1'b0) begin
            bad++;
            $display("FAIL majority_latency_early: got %b want 0", stable_valid);
        end
        wait_n(1);
        total++;
        if ({outs(), digit_changed} !== {1'b1, 4'd7, 4'd5, 1'b1}) begin
            bad++;
            $display("FAIL majority_result: got %h want %h", {outs(), digit_changed}, {1'b1, 4'd7, 4'd5, 1'b1});
        end
        wait_n(1);
        total++;
        if ({chg, busy, digit_changed} !== {32'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL majority_one_pulse: got chg=%0d busy=%b dc=%b want 1 0 0", chg, busy, digit_changed);
        end
    endtask

    task automatic test_switch();
        logic [8:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) feed(4'd7);
        total++;
        if (outs() !== {1'b1, 4'd7, 4'd8}) begin
            bad++;
            $display("FAIL switch_full7: got %h want %h", outs(), {1'b1, 4'd7, 4'd8});
        end
        chg = 0;
        for (int k = 1; k <= 8; k++) begin
            feed(4'd3);
            exp = (k < 5) ? {1'b1, 4'd7, 4'(8 - k)} : {1'b1, 4'd3, 4'(k)};
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL switch_step%0d: got %h want %h", k, outs(), exp);
            end
        end
        total++;
        if (chg != 1) begin
            bad++;
            $display("FAIL switch_pulses: got %0d want 1", chg);
        end
    endtask

    task automatic test_tie_history();
        logic [3:0] seq [8];
        seq = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd2};
        do_reset();
        for (int i = 0; i < 8; i++) feed(seq[i]);
        feed(4'd4);
        total++;
        if (outs() !== {1'b0, 4'hF, 4'd0}) begin
            bad++;
            $display("FAIL tie_below_threshold: got %h want %h", outs(), {1'b0, 4'hF, 4'd0});
        end
        feed(4'd2);
        total++;
        if (outs() !== {1'b1, 4'd2, 4'd5}) begin
            bad++;
            $display("FAIL tie_evict: got %h want %h", outs(), {1'b1, 4'd2, 4'd5});
        end
    endtask

    task automatic test_pending();
        do_reset();
        pulse(4'd7);
        wait_n(2);
        pulse(4'd9);
        pulse(4'd2);
        wait_n(19);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL pending_second_run: got busy=%b want 1", busy);
        end
        wait_n(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL pending_single_extra: got busy=%b want 0", busy);
        end
        wait_n(5);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL pending_no_third: got busy=%b want 0", busy);
        end
        for (int i = 0; i < 3; i++) feed(4'd2);
        total++;
        if (outs() !== {1'b0, 4'hF, 4'd0}) begin
            bad++;
            $display("FAIL pending_count4: got %h want %h", outs(), {1'b0, 4'hF, 4'd0});
        end
        feed(4'd2);
        total++;
        if (outs() !== {1'b1, 4'd2, 4'd5}) begin
            bad++;
            $display("FAIL pending_count5: got %h want %h", outs(), {1'b1, 4'd2, 4'd5});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) feed(4'd5);
        wait_n(99);
        total++;
        if (outs() !== {1'b1, 4'd5, 4'd5}) begin
            bad++;
            $display("FAIL timeout_before: got %h want %h", outs(), {1'b1, 4'd5, 4'd5});
        end
        pulse(4'd5);
        total++;
        if ({outs(), busy} !== {1'b1, 4'd5, 4'd5, 1'b1}) begin
            bad++;
            $display("FAIL timeout_cancel: got %h want %h", {outs(), busy}, {1'b1, 4'd5, 4'd5, 1'b1});
        end
        wait_n(12);
        total++;
        if (outs() !== {1'b1, 4'd5, 4'd6}) begin
            bad++;
            $display("FAIL timeout_cancel_processed: got %h want %h", outs(), {1'b1, 4'd5, 4'd6});
        end
        chg = 0;
        wait_n(99);
        total++;
        if (outs() !== {1'b1, 4'd5, 4'd6}) begin
            bad++;
            $display("FAIL timeout_early: got %h want %h", outs(), {1'b1, 4'd5, 4'd6});
        end
        wait_n(1);
        total++;
        if ({outs(), digit_changed} !== {1'b0, 4'hF, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL timeout_blank: got %h want %h", {outs(), digit_changed}, {1'b0, 4'hF, 4'd0, 1'b1});
        end
        feed(4'd5);
        total++;
        if ({outs(), chg} !== {1'b0, 4'hF, 4'd0, 32'd1}) begin
            bad++;
            $display("FAIL timeout_history_cleared: got %h chg=%0d want %h chg=1", outs(), chg, {1'b0, 4'hF, 4'd0});
        end
    endtask

    task automatic test_no_digit();
        int c6;
        logic [8:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) feed(4'd6);
        chg = 0;
        for (int k = 1; k <= 8; k++) begin
            feed(4'd12);
            c6  = (k <= 3) ? 5 : 8 - k;
            exp = (c6 >= 2) ? {1'b1, 4'd6, 4'(c6)} : {1'b0, 4'hF, 4'd0};
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL nodigit_step%0d: got %h want %h", k, outs(), exp);
            end
        end
        total++;
        if (chg != 1) begin
            bad++;
            $display("FAIL nodigit_pulses: got %0d want 1", chg);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        pulse(4'd7);
        wait_n(2);
        pulse(4'd3);
        wait_n(3);
        rst_n = 1'b0;
        #1;
        total++;
        if ({outs(), digit_changed, busy} !== {1'b0, 4'hF, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL midscan_async_reset: got %h want %h", {outs(), digit_changed, busy}, {1'b0, 4'hF, 4'd0, 2'b00});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(30);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midscan_pending_lost: got busy=%b want 0", busy);
        end
        for (int i = 0; i < 4; i++) feed(4'd7);
        total++;
        if (outs() !== {1'b0, 4'hF, 4'd0}) begin
            bad++;
            $display("FAIL midscan_counters_cleared: got %h want %h", outs(), {1'b0, 4'hF, 4'd0});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_majority();
        test_switch();
        test_tie_history();
        test_pending();
        test_timeout();
        test_no_digit();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
